// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters and the memory model that surround it.
interface mem_port_arbiter_if #(
    parameter int N = 64
);
    logic         if_req;
    logic [31:0]  if_adr;
    logic         if_ack;
    logic [31:0]  if_rdata;
    logic         d_req;
    logic [1:0]   d_we;
    logic [N-1:0] d_adr;
    logic [N-1:0] d_wdata;
    logic         d_ack;
    logic [N-1:0] d_rdata;
    logic [1:0]   m_memwrite;
    logic [N-1:0] m_adr;
    logic [N-1:0] m_wdata;
    logic [N-1:0] m_rdata;
    logic         busy;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, m_memwrite, m_adr, m_wdata, busy
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, m_memwrite, m_adr, m_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified memory between instruction fetch
// and data access. Each access runs IDLE -> ACCESS -> RESP; the owner gets a
// one-cycle ack with its read data. D wins ties unless IF has been passed over
// STARVE_MAX times in a row.
// Optional feature: define MEM_ARB_STATS_EN to add grant and stall counters.
module mem_port_arbiter #(
    parameter int N          = 64,
    parameter int LAT        = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]         if_grant_cnt,
    output logic [31:0]         d_grant_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int               SW       = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]       LAT_C    = 4'(LAT);
    localparam logic [SW-1:0]    STARVE_C = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state_q, state_nxt;
    logic [3:0]     cnt_q, cnt_nxt;
    logic [SW-1:0]  starve_q, starve_nxt;
    logic           owner_d_q, owner_d_nxt;     // 1: D owns the access, 0: IF
    logic           sel_lo_q, sel_lo_nxt;       // latched if_adr[2]
    logic [1:0]     memwrite_q, memwrite_nxt;
    logic [N-1:0]   adr_q, adr_nxt;
    logic [N-1:0]   wdata_q, wdata_nxt;
    logic           if_ack_q, if_ack_nxt;
    logic [31:0]    if_rdata_q, if_rdata_nxt;
    logic           d_ack_q, d_ack_nxt;
    logic [N-1:0]   d_rdata_q, d_rdata_nxt;
    logic           grant_d;
    logic           grant_if;

    // D wins unless IF has already been starved STARVE_MAX times.
    assign grant_d  = (state_q == IDLE) && bus.d_req &&
                      !(bus.if_req && (starve_q == STARVE_C));
    assign grant_if = (state_q == IDLE) && bus.if_req && !grant_d;

    assign bus.m_memwrite = memwrite_q;
    assign bus.m_adr      = adr_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.if_ack     = if_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.busy       = (state_q != IDLE);

    // State and every registered output; reset clears everything at once, even mid-access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            owner_d_q  <= 1'b0;
            sel_lo_q   <= 1'b0;
            memwrite_q <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            starve_q   <= starve_nxt;
            owner_d_q  <= owner_d_nxt;
            sel_lo_q   <= sel_lo_nxt;
            memwrite_q <= memwrite_nxt;
            adr_q      <= adr_nxt;
            wdata_q    <= wdata_nxt;
            if_ack_q   <= if_ack_nxt;
            if_rdata_q <= if_rdata_nxt;
            d_ack_q    <= d_ack_nxt;
            d_rdata_q  <= d_rdata_nxt;
        end
    end

    // Next-state: any request starts an access; the wait counter ends it.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.if_req || bus.d_req) state_nxt = ACCESS;
            ACCESS:  if (cnt_q == 4'd0)           state_nxt = RESP;
            RESP:                                 state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values: latch the grant, pulse the write, capture read data.
    always_comb begin
        cnt_nxt      = cnt_q;
        starve_nxt   = starve_q;
        owner_d_nxt  = owner_d_q;
        sel_lo_nxt   = sel_lo_q;
        memwrite_nxt = memwrite_q;
        adr_nxt      = adr_q;
        wdata_nxt    = wdata_q;
        if_ack_nxt   = if_ack_q;
        if_rdata_nxt = if_rdata_q;
        d_ack_nxt    = d_ack_q;
        d_rdata_nxt  = d_rdata_q;
        case (state_q)
            IDLE: begin
                // Starvation bookkeeping only matters while IF is waiting.
                if (!bus.if_req || grant_if) begin
                    starve_nxt = '0;
                end else if (grant_d && (starve_q != STARVE_C)) begin
                    starve_nxt = starve_q + SW'(1);
                end
                if (grant_d) begin
                    owner_d_nxt = 1'b1;
                    adr_nxt     = bus.d_adr;
                    cnt_nxt     = LAT_C;
                    if (bus.d_we != 2'd0) begin
                        memwrite_nxt = bus.d_we;
                        wdata_nxt    = bus.d_wdata;
                    end
                end else if (grant_if) begin
                    owner_d_nxt = 1'b0;
                    adr_nxt     = N'(bus.if_adr);
                    sel_lo_nxt  = bus.if_adr[2];
                    cnt_nxt     = LAT_C;
                end
            end
            ACCESS: begin
                // The write strobe lives only for the first access cycle.
                memwrite_nxt = 2'd0;
                if (cnt_q != 4'd0) begin
                    cnt_nxt = cnt_q - 4'd1;
                end else if (owner_d_q) begin
                    d_rdata_nxt = bus.m_rdata;
                    d_ack_nxt   = 1'b1;
                end else begin
                    if_rdata_nxt = sel_lo_q ? bus.m_rdata[31:0] : bus.m_rdata[63:32];
                    if_ack_nxt   = 1'b1;
                end
            end
            RESP: begin
                if_ack_nxt = 1'b0;
                d_ack_nxt  = 1'b0;
            end
            default: begin
                if_ack_nxt = 1'b0;
                d_ack_nxt  = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    // Grant counts per port and cycles spent with a request outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_grant_cnt <= '0;
            d_grant_cnt  <= '0;
            stall_cnt    <= '0;
        end else begin
            if (grant_if) if_grant_cnt <= if_grant_cnt + 32'd1;
            if (grant_d)  d_grant_cnt  <= d_grant_cnt + 32'd1;
            if ((bus.if_req || bus.d_req) && !(if_ack_q || d_ack_q))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (N=64, LAT=3, STARVE_MAX=4).
// Expected acks are queued when a request is driven and checked when an ack appears.
module tb_mem_port_arbiter;

    localparam int N = 64;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    typedef struct {
        logic        is_d;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];

    mem_port_arbiter_if #(.N(N)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt, d_grant_cnt, stall_cnt;
`endif

    mem_port_arbiter #(.N(N), .LAT(3), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_ARB_STATS_EN
        ,
        .if_grant_cnt (if_grant_cnt),
        .d_grant_cnt  (d_grant_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [63:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Wait for an ack, check it against the queue head and its latency, then
    // check that it lasted exactly one cycle.
    task automatic wait_ack(input string tag, input int exp_cycles);
        int   n;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.if_ack || bus.d_ack) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
            return;
        end
        if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_unexpected observed=ack expected=none", tag);
            return;
        end
        e = sbq.pop_front();
        if (exp_cycles >= 0) chk({tag, "_lat"}, 64'(n), 64'(exp_cycles));
        chk({tag, "_overlap"}, 64'(bus.if_ack && bus.d_ack), 64'd0);
        chk({tag, "_port"}, 64'(bus.d_ack), 64'(e.is_d));
        chk({tag, "_data"}, e.is_d ? 64'(bus.d_rdata) : {32'd0, bus.if_rdata}, e.data);
        @(posedge clk);
        #1;
        chk({tag, "_ackdrop"}, {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_memwrite"}, 64'(bus.m_memwrite), 64'd0);
        chk({tag, "_adr"},      64'(bus.m_adr),      64'd0);
        chk({tag, "_wdata"},    64'(bus.m_wdata),    64'd0);
        chk({tag, "_acks"},     {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
        chk({tag, "_rdata"},    64'(bus.d_rdata) | {32'd0, bus.if_rdata}, 64'd0);
        chk({tag, "_busy"},     64'(bus.busy),       64'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_adr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 2'd0;
        bus.d_adr   = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // D read
        bus.m_rdata = 64'hDEADBEEF_00000001;
        bus.d_req   = 1'b1;
        bus.d_we    = 2'd0;
        bus.d_adr   = 64'h10;
        push(1'b1, 64'hDEADBEEF_00000001);
        @(posedge clk);
        #1;
        chk("rd_adr", 64'(bus.m_adr), 64'h10);
        chk("rd_busy", 64'(bus.busy), 64'd1);
        chk("rd_nowrite", 64'(bus.m_memwrite), 64'd0);
        wait_ack("rd", 4);
        bus.d_req = 1'b0;

        // D word write
        bus.d_req   = 1'b1;
        bus.d_we    = 2'd1;
        bus.d_adr   = 64'h8;
        bus.d_wdata = 64'h12345678;
        push(1'b1, 64'hDEADBEEF_00000001);
        @(posedge clk);
        #1;
        chk("wr_memwrite", 64'(bus.m_memwrite), 64'd1);
        chk("wr_wdata", 64'(bus.m_wdata), 64'h12345678);
        chk("wr_adr", 64'(bus.m_adr), 64'h8);
        @(posedge clk);
        #1;
        chk("wr_pulse_end", 64'(bus.m_memwrite), 64'd0);
        wait_ack("wr", 3);
        chk("wr_adr_hold", 64'(bus.m_adr), 64'h8);
        bus.d_req = 1'b0;
        bus.d_we  = 2'd0;

        // IF fetches; the second changes if_adr and drops if_req mid-access
        bus.m_rdata = 64'h11112222_33334444;
        bus.if_req  = 1'b1;
        bus.if_adr  = 32'h4;
        push(1'b0, 64'h33334444);
        wait_ack("if_hi", 5);
        bus.if_adr = 32'h0;
        push(1'b0, 64'h11112222);
        @(posedge clk);
        #1;
        chk("if_lo_adr", 64'(bus.m_adr), 64'h0);
        bus.if_adr = 32'h4;
        bus.if_req = 1'b0;
        wait_ack("if_lo", 4);

        // Simultaneous requests: D first, IF right after
        bus.m_rdata = 64'hA5A5A5A5_5A5A5A5A;
        bus.if_adr  = 32'h4;
        bus.d_adr   = 64'h40;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        push(1'b1, 64'hA5A5A5A5_5A5A5A5A);
        push(1'b0, 64'h5A5A5A5A);
        wait_ack("both_d", 5);
        bus.d_req = 1'b0;
        wait_ack("both_if", 5);
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;

        // Continuous contention: D,D,D,D,IF repeating
        bus.if_adr = 32'h0;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) push(1'b0, 64'hA5A5A5A5);
            else            push(1'b1, 64'hA5A5A5A5_5A5A5A5A);
        end
        for (int g = 0; g < 10; g++) wait_ack($sformatf("starve%0d", g), 5);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(posedge clk);
        #1;

        // Dword write interrupted by reset, then re-granted
        bus.d_req   = 1'b1;
        bus.d_we    = 2'd3;
        bus.d_adr   = 64'h20;
        bus.d_wdata = 64'hCAFEF00D_01234567;
        @(posedge clk);
        #1;
        chk("dw_memwrite", 64'(bus.m_memwrite), 64'd3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        chk("rst_noack", 64'(bus.d_ack), 64'd0);
        reset = 1'b1;
        push(1'b1, 64'hA5A5A5A5_5A5A5A5A);
        @(posedge clk);
        #1;
        chk("regrant_memwrite", 64'(bus.m_memwrite), 64'd3);
        chk("regrant_adr", 64'(bus.m_adr), 64'h20);
        chk("regrant_wdata", 64'(bus.m_wdata), 64'hCAFEF00D_01234567);
        wait_ack("regrant", 4);
        bus.d_req = 1'b0;
        bus.d_we  = 2'd0;

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
